alu_exec: RTL and testbench

//   Execution end of the RS->ALU dispatch interface. Accepts at most one ready op per cycle

---
 rtl/alu_exec.sv | 178 +++++++++++++++++
 tb/tb_alu_exec.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec.sv
// alu_exec_pkg: operation encodings shared by the RS, ALU and bench.
// alu_exec: execution end of the RS->ALU dispatch path.
//   Accepts one op per cycle (no backpressure), computes integer, branch and
//   jump results, and registers them. The result is on the bus one cycle
//   after dispatch.
// Ports:
//   clk, rst (async, active high), rdy (global stall), clr (flush)
//   rs_to_alu_*   : dispatch request (enable, openum, rob_pos, rs1/rs2, imm, pc)
//   alu_result_*  : registered result (ready pulse, rob_pos, val, jump, pc)
//   alu_exec_count: executed ops since reset, wraps
package alu_exec_pkg;
  localparam int unsigned OP_LUI   = 1;
  localparam int unsigned OP_AUIPC = 2;
  localparam int unsigned OP_JAL   = 3;
  localparam int unsigned OP_JALR  = 4;
  localparam int unsigned OP_BEQ   = 5;
  localparam int unsigned OP_BNE   = 6;
  localparam int unsigned OP_BLT   = 7;
  localparam int unsigned OP_BGE   = 8;
  localparam int unsigned OP_BLTU  = 9;
  localparam int unsigned OP_BGEU  = 10;
  localparam int unsigned OP_ADDI  = 11;
  localparam int unsigned OP_SLTI  = 12;
  localparam int unsigned OP_SLTIU = 13;
  localparam int unsigned OP_XORI  = 14;
  localparam int unsigned OP_ORI   = 15;
  localparam int unsigned OP_ANDI  = 16;
  localparam int unsigned OP_SLLI  = 17;
  localparam int unsigned OP_SRLI  = 18;
  localparam int unsigned OP_SRAI  = 19;
  localparam int unsigned OP_ADD   = 20;
  localparam int unsigned OP_SUB   = 21;
  localparam int unsigned OP_SLL   = 22;
  localparam int unsigned OP_SLT   = 23;
  localparam int unsigned OP_SLTU  = 24;
  localparam int unsigned OP_XOR   = 25;
  localparam int unsigned OP_SRL   = 26;
  localparam int unsigned OP_SRA   = 27;
  localparam int unsigned OP_OR    = 28;
  localparam int unsigned OP_AND   = 29;
endpackage

module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int OPENUM_W  = 6,
  parameter int ROB_POS_W = 5,
  parameter int XLEN      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clr,
  input  logic                 rs_to_alu_enable,
  input  logic [OPENUM_W-1:0]  rs_to_alu_openum,
  input  logic [ROB_POS_W-1:0] rs_to_alu_rob_pos,
  input  logic [XLEN-1:0]      rs_to_alu_rs1_val,
  input  logic [XLEN-1:0]      rs_to_alu_rs2_val,
  input  logic [XLEN-1:0]      rs_to_alu_imm,
  input  logic [XLEN-1:0]      rs_to_alu_pc,
  output logic                 alu_result_ready,
  output logic [ROB_POS_W-1:0] alu_result_rob_pos,
  output logic [XLEN-1:0]      alu_result_val,
  output logic                 alu_result_jump,
  output logic [XLEN-1:0]      alu_result_pc,
  output logic [31:0]          alu_exec_count
);

  logic [31:0]     op;
  logic [XLEN-1:0] a, b, im, pc, pc4, pc_br, jalr_t;
  logic [4:0]      sh_r, sh_i;
  logic [XLEN-1:0] val_d, pc_d;
  logic            jump_d, take;

  assign op     = 32'(rs_to_alu_openum);
  assign a      = rs_to_alu_rs1_val;
  assign b      = rs_to_alu_rs2_val;
  assign im     = rs_to_alu_imm;
  assign pc     = rs_to_alu_pc;
  assign pc4    = pc + XLEN'(4);
  assign pc_br  = pc + im;
  assign jalr_t = a + im;
  assign sh_r   = b[4:0];
  assign sh_i   = im[4:0];

  always_comb begin
    val_d  = '0;
    jump_d = 1'b0;
    pc_d   = pc4;
    take   = 1'b0;
    case (op)
      OP_ADD:   val_d = a + b;
      OP_SUB:   val_d = a - b;
      OP_SLL:   val_d = a << sh_r;
      OP_SLT:   val_d = XLEN'($signed(a) < $signed(b));
      OP_SLTU:  val_d = XLEN'(a < b);
      OP_XOR:   val_d = a ^ b;
      OP_SRL:   val_d = a >> sh_r;
      OP_SRA:   val_d = XLEN'($signed(a) >>> sh_r);
      OP_OR:    val_d = a | b;
      OP_AND:   val_d = a & b;
      OP_ADDI:  val_d = a + im;
      OP_SLTI:  val_d = XLEN'($signed(a) < $signed(im));
      OP_SLTIU: val_d = XLEN'(a < im);
      OP_XORI:  val_d = a ^ im;
      OP_ORI:   val_d = a | im;
      OP_ANDI:  val_d = a & im;
      OP_SLLI:  val_d = a << sh_i;
      OP_SRLI:  val_d = a >> sh_i;
      OP_SRAI:  val_d = XLEN'($signed(a) >>> sh_i);
      OP_LUI:   val_d = im;
      OP_AUIPC: val_d = pc_br;
      OP_JAL: begin
        val_d  = pc4;
        jump_d = 1'b1;
        pc_d   = pc_br;
      end
      OP_JALR: begin
        val_d  = pc4;
        jump_d = 1'b1;
        pc_d   = {jalr_t[XLEN-1:1], 1'b0};
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        case (op)
          OP_BEQ:  take = (a == b);
          OP_BNE:  take = (a != b);
          OP_BLT:  take = ($signed(a) <  $signed(b));
          OP_BGE:  take = ($signed(a) >= $signed(b));
          OP_BLTU: take = (a <  b);
          default: take = (a >= b);
        endcase
        jump_d = take;
        pc_d   = take ? pc_br : pc4;
      end
      // Unknown ops still complete with val=0, so the ROB entry retires.
      default: ;
    endcase
  end

  logic                 ready_q;
  logic [ROB_POS_W-1:0] tag_q;
  logic [XLEN-1:0]      val_q, pc_q;
  logic                 jump_q;
  logic [31:0]          cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      tag_q   <= '0;
      val_q   <= '0;
      jump_q  <= 1'b0;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else if (rdy) begin
      if (clr) begin
        // Flush drops any same-cycle dispatch; the rest of the bus holds.
        ready_q <= 1'b0;
      end else if (rs_to_alu_enable) begin
        ready_q <= 1'b1;
        tag_q   <= rs_to_alu_rob_pos;
        val_q   <= val_d;
        jump_q  <= jump_d;
        pc_q    <= pc_d;
        cnt_q   <= cnt_q + 32'd1;
      end else begin
        ready_q <= 1'b0;
      end
    end
  end

  assign alu_result_ready   = ready_q;
  assign alu_result_rob_pos = tag_q;
  assign alu_result_val     = val_q;
  assign alu_result_jump    = jump_q;
  assign alu_result_pc      = pc_q;
  assign alu_exec_count     = cnt_q;

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;
  import alu_exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, clr, en;
  logic [5:0]  openum;
  logic [4:0]  tag_in;
  logic [31:0] rs1, rs2, imm, pc_in;
  logic        r_ready, r_jump;
  logic [4:0]  r_tag;
  logic [31:0] r_val, r_pc, r_cnt;

  alu_exec #(.OPENUM_W(6), .ROB_POS_W(5), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .rs_to_alu_enable(en), .rs_to_alu_openum(openum), .rs_to_alu_rob_pos(tag_in),
    .rs_to_alu_rs1_val(rs1), .rs_to_alu_rs2_val(rs2), .rs_to_alu_imm(imm),
    .rs_to_alu_pc(pc_in),
    .alu_result_ready(r_ready), .alu_result_rob_pos(r_tag), .alu_result_val(r_val),
    .alu_result_jump(r_jump), .alu_result_pc(r_pc), .alu_exec_count(r_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] val;
    logic        jump;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    int          op;
    logic [31:0] a, b, i, p, val;
    logic        jump;
    logic [31:0] npc;
  } vec_t;

  exp_t        sbq[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_cnt  = 0;

  task automatic issue(input int op, input logic [4:0] t, input logic [31:0] a, b, i, p);
    en = 1'b1; openum = op[5:0]; tag_in = t;
    rs1 = a; rs2 = b; imm = i; pc_in = p;
  endtask

  task automatic idle_in();
    en = 1'b0; openum = '0; tag_in = '0;
  endtask

  // Independent reference for register/immediate ALU ops.
  function automatic logic [31:0] ref_val(input int op, input logic [31:0] a, b, i);
    case (op)
      OP_ADD:   return a + b;
      OP_SUB:   return a - b;
      OP_SLL:   return a << b[4:0];
      OP_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      OP_XOR:   return a ^ b;
      OP_SRL:   return a >> b[4:0];
      OP_SRA:   return $unsigned($signed(a) >>> b[4:0]);
      OP_OR:    return a | b;
      OP_AND:   return a & b;
      OP_ADDI:  return a + i;
      OP_SLTI:  return ($signed(a) < $signed(i)) ? 32'd1 : 32'd0;
      OP_SLTIU: return (a < i) ? 32'd1 : 32'd0;
      OP_XORI:  return a ^ i;
      OP_ORI:   return a | i;
      OP_ANDI:  return a & i;
      OP_SLLI:  return a << i[4:0];
      OP_SRLI:  return a >> i[4:0];
      OP_SRAI:  return $unsigned($signed(a) >>> i[4:0]);
      default:  return 32'd0;
    endcase
  endfunction

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; idle_in();
    rs1 = '0; rs2 = '0; imm = '0; pc_in = '0;
    #1;
    n_assert++;
    if ({r_ready, r_tag, r_val, r_jump, r_pc, r_cnt} !== '0) begin
      n_fail++;
      $display("FAIL reset: got ready=%b tag=%0d val=%h jump=%b pc=%h cnt=%0d want all 0",
               r_ready, r_tag, r_val, r_jump, r_pc, r_cnt);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs a vector list back-to-back; one result is checked per cycle.
  task automatic test_vectors(input string name, input vec_t tv[$]);
    exp_t e;
    for (int k = 0; k <= tv.size(); k++) begin
      @(negedge clk);
      if (k > 0) begin
        e = '0;
        if (sbq.size() > 0) e = sbq.pop_front();
        n_assert++;
        if (r_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL %s ready[%0d]: got %b want 1", name, k-1, r_ready);
        end
        n_assert++;
        if ({r_tag, r_val, r_jump, r_pc} !== e) begin
          n_fail++;
          $display("FAIL %s result[%0d]: got tag=%0d val=%h jump=%b pc=%h want tag=%0d val=%h jump=%b pc=%h",
                   name, k-1, r_tag, r_val, r_jump, r_pc, e.tag, e.val, e.jump, e.pc);
        end
        n_assert++;
        if (r_cnt !== exp_cnt) begin
          n_fail++;
          $display("FAIL %s count[%0d]: got %0d want %0d", name, k-1, r_cnt, exp_cnt);
        end
      end
      if (k < tv.size()) begin
        logic [4:0] t;
        t = 5'(((k + 2) % 31) + 1);
        issue(tv[k].op, t, tv[k].a, tv[k].b, tv[k].i, tv[k].p);
        sbq.push_back({t, tv[k].val, tv[k].jump, tv[k].npc});
        exp_cnt++;
      end else idle_in();
    end
  endtask

  task automatic test_arith();
    vec_t tv[$];
    tv.push_back('{OP_ADD,   32'd5,        32'hFFFFFFFF, 32'hDEAD0000, 32'h100, 32'd4,        1'b0, 32'h104});
    tv.push_back('{OP_SRAI,  32'h80000000, 32'h00000001, 32'h24,       32'h100, 32'hF8000000, 1'b0, 32'h104});
    tv.push_back('{OP_SLTU,  32'd1,        32'hFFFFFFFF, 32'h0,        32'h100, 32'd1,        1'b0, 32'h104});
    tv.push_back('{OP_SLT,   32'd1,        32'hFFFFFFFF, 32'h7,        32'h100, 32'd0,        1'b0, 32'h104});
    tv.push_back('{OP_SUB,   32'd0,        32'd1,        32'h5,        32'h100, 32'hFFFFFFFF, 1'b0, 32'h104});
    tv.push_back('{OP_SLL,   32'd1,        32'h21,       32'h3,        32'h100, 32'd2,        1'b0, 32'h104});
    tv.push_back('{OP_SRL,   32'h80000000, 32'd4,        32'h1,        32'h100, 32'h08000000, 1'b0, 32'h104});
    tv.push_back('{OP_SRA,   32'h80000000, 32'd4,        32'h1,        32'h100, 32'hF8000000, 1'b0, 32'h104});
    tv.push_back('{OP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h100, 32'h0FF00FF0, 1'b0, 32'h104});
    tv.push_back('{OP_OR,    32'hF0F0F0F0, 32'h0F0F0000, 32'h0,        32'h100, 32'hFFFFF0F0, 1'b0, 32'h104});
    tv.push_back('{OP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 32'h0,        32'h100, 32'hF000F000, 1'b0, 32'h104});
    tv.push_back('{OP_ADDI,  32'd16,       32'h3,        32'hFFFFFFFF, 32'h100, 32'd15,       1'b0, 32'h104});
    tv.push_back('{OP_SLTI,  32'hFFFFFFFE, 32'h0,        32'd1,        32'h100, 32'd1,        1'b0, 32'h104});
    tv.push_back('{OP_SLTIU, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1,        32'h100, 32'd0,        1'b0, 32'h104});
    tv.push_back('{OP_XORI,  32'h000000FF, 32'h0,        32'hFFFFFFFF, 32'h100, 32'hFFFFFF00, 1'b0, 32'h104});
    tv.push_back('{OP_ORI,   32'h0000000F, 32'h0,        32'h000000F0, 32'h100, 32'h000000FF, 1'b0, 32'h104});
    tv.push_back('{OP_ANDI,  32'h000000FF, 32'hFFFFFFFF, 32'h0000000F, 32'h100, 32'h0000000F, 1'b0, 32'h104});
    tv.push_back('{OP_SLLI,  32'd1,        32'h0,        32'h1F,       32'h100, 32'h80000000, 1'b0, 32'h104});
    tv.push_back('{OP_SRLI,  32'h80000000, 32'h0,        32'h1F,       32'h100, 32'd1,        1'b0, 32'h104});
    tv.push_back('{OP_LUI,   32'h1111,     32'h2222,     32'h12345000, 32'h100, 32'h12345000, 1'b0, 32'h104});
    tv.push_back('{OP_AUIPC, 32'h1111,     32'h2222,     32'h2000,     32'h1000, 32'h3000,    1'b0, 32'h1004});
    tv.push_back('{0,        32'h1,        32'h2,        32'h3,        32'h100, 32'd0,        1'b0, 32'h104});
    tv.push_back('{63,       32'h1,        32'h2,        32'h3,        32'hFFFFFFFC, 32'd0,   1'b0, 32'h0});
    test_vectors("arith", tv);
  endtask

  task automatic test_branch();
    vec_t tv[$];
    tv.push_back('{OP_BLT,  32'hFFFFFFFF, 32'd0, 32'hFFFFFFF8, 32'h100, 32'd0,  1'b1, 32'hF8});
    tv.push_back('{OP_BGEU, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFF8, 32'h100, 32'd0,  1'b1, 32'hF8});
    tv.push_back('{OP_BEQ,  32'd1,        32'd2, 32'hFFFFFFF8, 32'h100, 32'd0,  1'b0, 32'h104});
    tv.push_back('{OP_BNE,  32'd1,        32'd2, 32'h20,       32'h100, 32'd0,  1'b1, 32'h120});
    tv.push_back('{OP_BGE,  32'hFFFFFFFF, 32'd0, 32'h20,       32'h100, 32'd0,  1'b0, 32'h104});
    tv.push_back('{OP_BLTU, 32'hFFFFFFFF, 32'd0, 32'h20,       32'h100, 32'd0,  1'b0, 32'h104});
    tv.push_back('{OP_BEQ,  32'd7,        32'd7, 32'h10,       32'h200, 32'd0,  1'b1, 32'h210});
    tv.push_back('{OP_JAL,  32'd0,        32'd0, 32'h100,      32'h40,  32'h44, 1'b1, 32'h140});
    tv.push_back('{OP_JALR, 32'h2001,     32'd9, 32'd2,        32'h40,  32'h44, 1'b1, 32'h2002});
    test_vectors("branch", tv);
  endtask

  // A, B back-to-back, C dispatched together with clr and must vanish.
  task automatic test_back_to_back();
    exp_t e;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 1 || k == 2) begin
        e = '0;
        if (sbq.size() > 0) e = sbq.pop_front();
        n_assert++;
        if ({r_ready, r_tag, r_val, r_jump, r_pc} !== {1'b1, e}) begin
          n_fail++;
          $display("FAIL b2b result[%0d]: got ready=%b tag=%0d val=%h want ready=1 tag=%0d val=%h",
                   k, r_ready, r_tag, r_val, e.tag, e.val);
        end
      end
      if (k >= 3) begin
        n_assert++;
        if (r_ready !== 1'b0 || r_tag !== 5'd2 || r_cnt !== exp_cnt) begin
          n_fail++;
          $display("FAIL b2b clr[%0d]: got ready=%b tag=%0d cnt=%0d want ready=0 tag=2 cnt=%0d",
                   k, r_ready, r_tag, r_cnt, exp_cnt);
        end
      end
      case (k)
        0: begin issue(OP_ADD, 5'd1, 32'd10, 32'd20, 32'd0, 32'h300);
                 sbq.push_back({5'd1, 32'd30, 1'b0, 32'h304}); exp_cnt++; end
        1: begin issue(OP_SUB, 5'd2, 32'd10, 32'd3, 32'd0, 32'h304);
                 sbq.push_back({5'd2, 32'd7, 1'b0, 32'h308}); exp_cnt++; end
        2: begin issue(OP_OR, 5'd3, 32'hF0, 32'h0F, 32'd0, 32'h308); clr = 1'b1; end
        default: begin idle_in(); clr = 1'b0; end
      endcase
    end
  endtask

  // Random R/I ops with random gaps; checks every cycle, including idle ones.
  task automatic test_random();
    int   ops[19] = '{OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
                      OP_OR, OP_AND, OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
                      OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI};
    logic pend = 1'b0;
    exp_t e;
    for (int k = 0; k <= 60; k++) begin
      @(negedge clk);
      if (pend) begin
        e = '0;
        if (sbq.size() > 0) e = sbq.pop_front();
        n_assert++;
        if ({r_ready, r_tag, r_val, r_jump, r_pc, r_cnt} !== {1'b1, e, exp_cnt}) begin
          n_fail++;
          $display("FAIL random[%0d]: got ready=%b tag=%0d val=%h pc=%h cnt=%0d want ready=1 tag=%0d val=%h pc=%h cnt=%0d",
                   k, r_ready, r_tag, r_val, r_pc, r_cnt, e.tag, e.val, e.pc, exp_cnt);
        end
      end else if (k > 0) begin
        n_assert++;
        if (r_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL random idle[%0d]: got ready=%b want 0", k, r_ready);
        end
      end
      pend = 1'b0;
      if (k < 60 && $urandom_range(0, 3) != 0) begin
        int          op;
        logic [31:0] a, b, i, p;
        logic [4:0]  t;
        op = ops[$urandom_range(0, 18)];
        a  = ($urandom_range(0, 3) == 0) ? 32'h80000000 : 32'($urandom);
        b  = 32'($urandom);
        i  = ($urandom_range(0, 1) == 0) ? 32'hFFFFF800 | 32'($urandom_range(0, 2047)) : 32'($urandom_range(0, 2047));
        p  = 32'($urandom) & 32'hFFFFFFFC;
        t  = 5'($urandom_range(1, 31));
        issue(op, t, a, b, i, p);
        sbq.push_back({t, ref_val(op, a, b, i), 1'b0, p + 32'd4});
        exp_cnt++;
        pend = 1'b1;
      end else idle_in();
    end
  endtask

  // Stall with a live result, then idle hold, then async reset mid-cycle.
  task automatic test_hold_reset();
    exp_t e;
    @(negedge clk);
    issue(OP_ADD, 5'd5, 32'd1, 32'd2, 32'd0, 32'h200);
    e = {5'd5, 32'd3, 1'b0, 32'h204};
    exp_cnt++;
    @(negedge clk);
    rdy = 1'b0;
    issue(OP_SUB, 5'd6, 32'd9, 32'd1, 32'd0, 32'h500);  // must be ignored while stalled
    for (int k = 0; k < 3; k++) begin
      n_assert++;
      if ({r_ready, r_tag, r_val, r_jump, r_pc, r_cnt} !== {1'b1, e, exp_cnt}) begin
        n_fail++;
        $display("FAIL hold[%0d]: got ready=%b tag=%0d val=%h pc=%h cnt=%0d want ready=1 tag=5 val=3 pc=204 cnt=%0d",
                 k, r_ready, r_tag, r_val, r_pc, r_cnt, exp_cnt);
      end
      if (k < 2) @(negedge clk);
    end
    rdy = 1'b1; idle_in();
    @(negedge clk);
    n_assert++;
    if ({r_ready, r_tag, r_val, r_jump, r_pc, r_cnt} !== {1'b0, e, exp_cnt}) begin
      n_fail++;
      $display("FAIL idle hold: got ready=%b tag=%0d val=%h pc=%h cnt=%0d want ready=0 tag=5 val=3 pc=204 cnt=%0d",
               r_ready, r_tag, r_val, r_pc, r_cnt, exp_cnt);
    end
    issue(OP_JAL, 5'd7, 32'd0, 32'd0, 32'h40, 32'h80);
    exp_cnt++;
    @(negedge clk);
    idle_in();
    n_assert++;
    if ({r_ready, r_tag, r_jump, r_pc} !== {1'b1, 5'd7, 1'b1, 32'hC0}) begin
      n_fail++;
      $display("FAIL pre-reset jal: got ready=%b tag=%0d jump=%b pc=%h want ready=1 tag=7 jump=1 pc=c0",
               r_ready, r_tag, r_jump, r_pc);
    end
    #2 rst = 1'b1;
    #1;
    n_assert++;
    if ({r_ready, r_tag, r_val, r_jump, r_pc, r_cnt} !== '0) begin
      n_fail++;
      $display("FAIL async reset: got ready=%b tag=%0d val=%h jump=%b pc=%h cnt=%0d want all 0",
               r_ready, r_tag, r_val, r_jump, r_pc, r_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 0;
    issue(OP_XORI, 5'd9, 32'h0F, 32'd0, 32'hFF, 32'h10);
    exp_cnt++;
    @(negedge clk);
    idle_in();
    n_assert++;
    if ({r_ready, r_tag, r_val, r_cnt} !== {1'b1, 5'd9, 32'hF0, 32'd1}) begin
      n_fail++;
      $display("FAIL after reset: got ready=%b tag=%0d val=%h cnt=%0d want ready=1 tag=9 val=f0 cnt=1",
               r_ready, r_tag, r_val, r_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_branch();
    test_back_to_back();
    test_random();
    test_hold_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
